// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB encodings and bridge FSM states for ahb_apb_bridge_mc.
// Optional byte-strobe feature: AHB_APB_PSTRB_EN.
package ahb_apb_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_BUSY   = 2'b01,
      HT_NONSEQ = 2'b10,
      HT_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [1:0] {
      HR_OKAY  = 2'b00,
      HR_ERROR = 2'b01
   } hresp_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_ERR1,
      S_ERR2
   } state_e;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational APB window decode: range check and one-hot select.
// Each peripheral owns a 2**SLV_AW byte window above BASE_ADDR.
module apb_addr_decode #(
   parameter int               WIDTH     = 32,
   parameter int               NUM_SLV   = 4,
   parameter logic [WIDTH-1:0] BASE_ADDR = 'h8000_0000,
   parameter int               SLV_AW    = 12
) (
   input  logic [WIDTH-1:0]   addr,
   output logic               in_range,
   output logic [NUM_SLV-1:0] sel
);

   localparam int IDXW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   localparam logic [WIDTH-1:0] NSLV = WIDTH'(NUM_SLV);

   logic [WIDTH-1:0] offset;
   logic [WIDTH-1:0] win;
   logic [IDXW-1:0]  idx;

   // Compare the window number rather than an end address so the
   // top of the region can never overflow.
   always_comb begin
      offset   = addr - BASE_ADDR;
      win      = offset >> SLV_AW;
      in_range = (addr >= BASE_ADDR) && (win < NSLV);
      idx      = win[IDXW-1:0];
      sel      = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         sel[i] = in_range && (idx == IDXW'(i));
      end
   end

endmodule

// File: rtl/ahb_apb_bridge_mc.sv
// AHB-Lite slave to multi-select APB master bridge with wait states,
// error responses and ACCESS timeout. Optional: AHB_APB_PSTRB_EN.
module ahb_apb_bridge_mc
   import ahb_apb_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter int               NUM_SLV   = 4,
   parameter logic [WIDTH-1:0] BASE_ADDR = 'h8000_0000,
   parameter int               SLV_AW    = 12,
   parameter int               TIMEOUT   = 16
) (
   input  logic               Hclk,
   input  logic               Hresetn,
   input  logic [1:0]         Htrans,
   input  logic               Hwrite,
   input  logic [2:0]         Hsize,
   input  logic               Hreadyin,
   input  logic [WIDTH-1:0]   Haddr,
   input  logic [WIDTH-1:0]   Hwdata,
   output logic [WIDTH-1:0]   Hrdata,
   output logic [1:0]         Hresp,
   output logic               Hreadyout,
   output logic [NUM_SLV-1:0] Pselx,
   output logic               Penable,
   output logic               Pwrite,
   output logic [WIDTH-1:0]   Paddr,
   output logic [WIDTH-1:0]   Pwdata,
   input  logic [WIDTH-1:0]   Prdata,
   input  logic               Pready,
   input  logic               Pslverr
`ifdef AHB_APB_PSTRB_EN
   ,
   output logic [WIDTH/8-1:0] Pstrb
`endif
);

   localparam int BL = $clog2(WIDTH / 8);
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               hready_q, hready_d;
   logic [1:0]         hresp_q, hresp_d;
   logic [WIDTH-1:0]   hrdata_q, hrdata_d;
   logic [NUM_SLV-1:0] psel_q, psel_d;
   logic               pen_q, pen_d;
   logic               pwrite_q, pwrite_d;
   logic [WIDTH-1:0]   paddr_q, paddr_d;
   logic [2:0]         size_q, size_d;

   logic               xfer_vld;
   logic               in_range;
   logic               legal;
   logic               aligned;
   logic [NUM_SLV-1:0] dec_sel;
   logic               unused_in;

   apb_addr_decode #(
      .WIDTH    (WIDTH),
      .NUM_SLV  (NUM_SLV),
      .BASE_ADDR(BASE_ADDR),
      .SLV_AW   (SLV_AW)
   ) u_dec (
      .addr    (Haddr),
      .in_range(in_range),
      .sel     (dec_sel)
   );

   assign xfer_vld = Hreadyin && hready_q && Htrans[1];

`ifdef AHB_APB_PSTRB_EN
   logic [BL-1:0] amask;

   always_comb begin
      amask = BL'((1 << Hsize) - 1);
   end

   assign aligned = (Haddr[BL-1:0] & amask) == '0;

   always_comb begin
      Pstrb = '0;
      if (pwrite_q) begin
         Pstrb = (WIDTH/8)'(((1 << (1 << size_q)) - 1)
                 << paddr_q[BL-1:0]);
      end
   end

   assign unused_in = Htrans[0];
`else
   assign aligned   = 1'b1;
   assign unused_in = ^{Htrans[0], size_q};
`endif

   assign legal = (Hsize <= 3'(BL)) && aligned;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hready_d = hready_q;
      hresp_d  = hresp_q;
      hrdata_d = hrdata_q;
      psel_d   = psel_q;
      pen_d    = pen_q;
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
      size_d   = size_q;
      unique case (state_q)
         S_IDLE, S_ERR2: begin
            state_d  = S_IDLE;
            hready_d = 1'b1;
            hresp_d  = HRESP_OKAY;
            psel_d   = '0;
            pen_d    = 1'b0;
            if (xfer_vld) begin
               hready_d = 1'b0;
               if (in_range && legal) begin
                  state_d  = S_SETUP;
                  psel_d   = dec_sel;
                  pwrite_d = Hwrite;
                  paddr_d  = Haddr;
                  size_d   = Hsize;
                  cnt_d    = '0;
               end else begin
                  state_d = S_ERR1;
                  hresp_d = HRESP_ERROR;
               end
            end
         end
         S_SETUP: begin
            state_d = S_ACCESS;
            pen_d   = 1'b1;
         end
         S_ACCESS: begin
            if (Pready) begin
               psel_d = '0;
               pen_d  = 1'b0;
               if (Pslverr) begin
                  state_d = S_ERR1;
                  hresp_d = HRESP_ERROR;
               end else begin
                  state_d  = S_IDLE;
                  hready_d = 1'b1;
                  if (!pwrite_q) begin
                     hrdata_d = Prdata;
                  end
               end
            end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
               // Slave never answered: abandon the APB access.
               state_d = S_ERR1;
               hresp_d = HRESP_ERROR;
               psel_d  = '0;
               pen_d   = 1'b0;
               cnt_d   = TO_MAX;
            end else if (cnt_q != TO_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_ERR1: begin
            state_d  = S_ERR2;
            hready_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         hready_q <= 1'b1;
         hresp_q  <= HRESP_OKAY;
         hrdata_q <= '0;
         psel_q   <= '0;
         pen_q    <= 1'b0;
         pwrite_q <= 1'b0;
         paddr_q  <= '0;
         size_q   <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hready_q <= hready_d;
         hresp_q  <= hresp_d;
         hrdata_q <= hrdata_d;
         psel_q   <= psel_d;
         pen_q    <= pen_d;
         pwrite_q <= pwrite_d;
         paddr_q  <= paddr_d;
         size_q   <= size_d;
      end
   end

   assign Hrdata    = hrdata_q;
   assign Hresp     = hresp_q;
   assign Hreadyout = hready_q;
   assign Pselx     = psel_q;
   assign Penable   = pen_q;
   assign Pwrite    = pwrite_q;
   assign Paddr     = paddr_q;
   assign Pwdata    = Hwdata;

endmodule

// File: tb/tb_ahb_apb_bridge_mc.sv
// Scoreboard bench for ahb_apb_bridge_mc: AHB driver, APB slave model,
// expected responses queued at issue and checked at completion.
module tb_ahb_apb_bridge_mc;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] rdata;
      bit          chk_rd;
      logic [3:0]  sel;
      logic [31:0] addr;
      int          lat;
   } exp_t;

   logic        Hclk = 1'b0;
   logic        Hresetn;
   logic [1:0]  Htrans;
   logic        Hwrite;
   logic [2:0]  Hsize;
   logic        Hreadyin;
   logic [31:0] Haddr;
   logic [31:0] Hwdata;
   logic [31:0] Hrdata;
   logic [1:0]  Hresp;
   logic        Hreadyout;
   logic [3:0]  Pselx;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic [31:0] Prdata;
   logic        Pready;
   logic        Pslverr;
`ifdef AHB_APB_PSTRB_EN
   logic [3:0]  Pstrb;
`endif

   int   n_run  = 0;
   int   n_fail = 0;
   exp_t sb[$];

   int   wait_n  = 0;
   bit   err_f   = 0;
   int   acc_cnt = 0;

   ahb_apb_bridge_mc dut (
      .Hclk     (Hclk),
      .Hresetn  (Hresetn),
      .Htrans   (Htrans),
      .Hwrite   (Hwrite),
      .Hsize    (Hsize),
      .Hreadyin (Hreadyin),
      .Haddr    (Haddr),
      .Hwdata   (Hwdata),
      .Hrdata   (Hrdata),
      .Hresp    (Hresp),
      .Hreadyout(Hreadyout),
      .Pselx    (Pselx),
      .Penable  (Penable),
      .Pwrite   (Pwrite),
      .Paddr    (Paddr),
      .Pwdata   (Pwdata),
      .Prdata   (Prdata),
      .Pready   (Pready),
      .Pslverr  (Pslverr)
`ifdef AHB_APB_PSTRB_EN
      ,
      .Pstrb    (Pstrb)
`endif
   );

   always #5 Hclk = ~Hclk;

   // APB slave: Pready rises after wait_n ACCESS cycles.
   always @(negedge Hclk) begin
      if (Penable) begin
         Pready  = (acc_cnt == wait_n);
         Pslverr = err_f && (acc_cnt == wait_n);
         acc_cnt++;
      end else begin
         Pready  = 1'b0;
         Pslverr = 1'b0;
         acc_cnt = 0;
      end
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [1:0] resp,
                               input logic [31:0] rdata,
                               input bit chk_rd, input logic [3:0] sel,
                               input logic [31:0] addr, input int lat);
      exp_t e;
      e.resp   = resp;
      e.rdata  = rdata;
      e.chk_rd = chk_rd;
      e.sel    = sel;
      e.addr   = addr;
      e.lat    = lat;
      return e;
   endfunction

   // Called at a negedge; returns at the negedge of cycle N+1.
   task automatic issue(input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] wd,
                        input bit push, input exp_t e);
      int g;
      g = 0;
      while (!Hreadyout && g < 50) begin
         @(negedge Hclk);
         g++;
      end
      Htrans = 2'b10;
      Haddr  = a;
      Hwrite = w;
      Hsize  = sz;
      if (push) sb.push_back(e);
      @(posedge Hclk);
      @(negedge Hclk);
      Htrans = 2'b00;
      Hwdata = wd;
   endtask

   task automatic complete(input string tag, input logic [31:0] wd);
      exp_t e;
      int   k;
      int   bad;
      bit   done;
      e    = sb.pop_front();
      k    = 1;
      bad  = 0;
      done = 0;
      check({tag, " sel_setup"}, Pselx, e.sel);
      check({tag, " pen_setup"}, Penable, 0);
      if (e.sel != 0) check({tag, " paddr"}, Paddr, e.addr);
      while (!done && k < 40) begin
         if (k == 2 && e.sel != 0)
            check({tag, " pen_access"}, Penable, 1);
         if (Pselx != 0 && Pwrite && Pwdata !== wd) bad++;
         if (Hresp == 2'b01 && !Hreadyout) begin
            check({tag, " err1_sel"}, Pselx, 0);
            check({tag, " err1_pen"}, Penable, 0);
         end
         if (Hreadyout) begin
            done = 1;
         end else begin
            @(negedge Hclk);
            k++;
         end
      end
      check({tag, " latency"}, done ? k : -1, e.lat);
      check({tag, " resp"}, Hresp, e.resp);
      if (e.chk_rd) check({tag, " rdata"}, Hrdata, e.rdata);
      check({tag, " pwdata"}, bad, 0);
   endtask

   task automatic check_reset_outs(input string tag);
      check({tag, " hready"}, Hreadyout, 1);
      check({tag, " hresp"}, Hresp, 0);
      check({tag, " hrdata"}, Hrdata, 0);
      check({tag, " psel"}, Pselx, 0);
      check({tag, " pen"}, Penable, 0);
      check({tag, " pwrite"}, Pwrite, 0);
      check({tag, " paddr"}, Paddr, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Hresetn  = 1'b0;
      Htrans   = 2'b00;
      Hwrite   = 1'b0;
      Hsize    = 3'd2;
      Hreadyin = 1'b1;
      Haddr    = '0;
      Hwdata   = '0;
      Prdata   = '0;
      repeat (3) @(negedge Hclk);
      check_reset_outs("reset");
      Hresetn = 1'b1;
      @(negedge Hclk);

      Prdata = 32'hDEAD_BEEF;
      wait_n = 0;
      issue(32'h8000_1004, 1'b0, 3'd2, 32'h0, 1,
            mk(2'b00, 32'hDEAD_BEEF, 1, 4'b0010, 32'h8000_1004, 3));
      complete("rd0", 32'h0);

      wait_n = 3;
      issue(32'h8000_3000, 1'b1, 3'd2, 32'h1234_5678, 1,
            mk(2'b00, 32'h0, 0, 4'b1000, 32'h8000_3000, 6));
      complete("wr3", 32'h1234_5678);
      check("wr3 hrdata_hold", Hrdata, 32'hDEAD_BEEF);

      wait_n = 0;
      issue(32'h8000_4000, 1'b0, 3'd2, 32'h0, 1,
            mk(2'b01, 32'h0, 0, 4'b0000, 32'h0, 2));
      complete("oor_hi", 32'h0);

      issue(32'h7FFF_FFFC, 1'b0, 3'd2, 32'h0, 1,
            mk(2'b01, 32'h0, 0, 4'b0000, 32'h0, 2));
      complete("oor_lo", 32'h0);

      issue(32'h8000_0000, 1'b1, 3'd3, 32'h55, 1,
            mk(2'b01, 32'h0, 0, 4'b0000, 32'h0, 2));
      complete("size", 32'h55);

      err_f = 1;
      issue(32'h8000_2008, 1'b0, 3'd2, 32'h0, 1,
            mk(2'b01, 32'h0, 0, 4'b0100, 32'h8000_2008, 4));
      complete("slverr", 32'h0);
      err_f = 0;

      wait_n = 1000;
      issue(32'h8000_0010, 1'b0, 3'd2, 32'h0, 1,
            mk(2'b01, 32'h0, 0, 4'b0001, 32'h8000_0010, 19));
      complete("tmo", 32'h0);
      wait_n = 0;

      Prdata = 32'h0000_CAFE;
      issue(32'h8000_0002, 1'b0, 3'd1, 32'h0, 1,
            mk(2'b00, 32'h0000_CAFE, 1, 4'b0001, 32'h8000_0002, 3));
      complete("half", 32'h0);

      Htrans = 2'b01;
      Haddr  = 32'h8000_0000;
      @(posedge Hclk);
      @(negedge Hclk);
      check("busy hready", Hreadyout, 1);
      check("busy hresp", Hresp, 0);
      check("busy psel", Pselx, 0);
      Htrans = 2'b00;

      Prdata = 32'h1111_2222;
      issue(32'h8000_0100, 1'b0, 3'd2, 32'h0, 1,
            mk(2'b00, 32'h1111_2222, 1, 4'b0001, 32'h8000_0100, 3));
      complete("b2b_a", 32'h0);
      Prdata = 32'h3333_4444;
      issue(32'h8000_2200, 1'b0, 3'd2, 32'h0, 1,
            mk(2'b00, 32'h3333_4444, 1, 4'b0100, 32'h8000_2200, 3));
      complete("b2b_b", 32'h0);

      wait_n = 1000;
      issue(32'h8000_1010, 1'b1, 3'd2, 32'h0000_AAAA, 0,
            mk(2'b00, 32'h0, 0, 4'b0, 32'h0, 0));
      @(negedge Hclk);
      check("rst_mid pen", Penable, 1);
      check("rst_mid psel", Pselx, 4'b0010);
      Hresetn = 1'b0;
      #1;
      check_reset_outs("rst_mid");
      @(negedge Hclk);
      Hresetn = 1'b1;
      wait_n  = 0;
      @(negedge Hclk);

      Prdata = 32'h5A5A_A5A5;
      issue(32'h8000_0004, 1'b0, 3'd2, 32'h0, 1,
            mk(2'b00, 32'h5A5A_A5A5, 1, 4'b0001, 32'h8000_0004, 3));
      complete("post_rst", 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_apb_bridge_mc.md
# ahb_apb_bridge_mc

Parametrised AHB-Lite slave to multi-peripheral APB master bridge, single clock domain. It accepts AHB transfers and decodes them to one of NUM_SLV APB peripheral selects. It runs the APB SETUP/ACCESS protocol with wait-state support and returns read data or the two-cycle AHB ERROR response. Out-of-range addresses, illegal sizes, PSLVERR and PREADY timeouts all produce ERROR. It sits between the AHB interconnect and the APB peripheral cluster and replaces the fixed single-select bridge.

## Interface
- WIDTH, 32: address and data width (32 or 64).
- NUM_SLV, 4: APB peripheral count, 1..16.
- BASE_ADDR, 32'h8000_0000: start of the APB region.
- SLV_AW, 12: log2 of the bytes per peripheral window.
- TIMEOUT, 16: maximum ACCESS cycles with Pready low; 0 disables the timeout.

Ports:
- Hclk  in  1  clock; the APB side also runs on it.
- Hresetn  in  1  reset, asynchronous, active-low.
- Htrans  in  2  AHB transfer type: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
- Hwrite  in  1  write when 1.
- Hsize  in  3  transfer size.
- Hreadyin  in  1  bus HREADY.
- Haddr  in  WIDTH  address.
- Hwdata  in  WIDTH  write data.
- Hrdata  out  WIDTH  read data, registered.
- Hresp  out  2  OKAY 00, ERROR 01.
- Hreadyout  out  1  slave ready.
- Pselx  out  NUM_SLV  one-hot peripheral select.
- Penable  out  1  APB enable.
- Pwrite  out  1  APB direction.
- Paddr  out  WIDTH  APB address, registered.
- Pwdata  out  WIDTH  APB write data.
- Prdata  in  WIDTH  APB read data.
- Pready  in  1  APB ready.
- Pslverr  in  1  APB slave error.

## Operation
- A transfer is valid when Hreadyin && Hreadyout && Htrans[1] on a rising edge. On that edge Haddr, Hwrite, Hsize and the decode result are registered.
- Decode: the address is in range when BASE_ADDR <= Haddr < BASE_ADDR + (NUM_SLV << SLV_AW). The select index is (Haddr - BASE_ADDR) >> SLV_AW.
- Size check: Hsize > log2(WIDTH/8) is illegal.
- IDLE or BUSY transfers get a zero-wait OKAY; no APB activity results.
- State machine IDLE, SETUP, ACCESS, ERR1, ERR2:
  - IDLE: Hreadyout=1. A valid transfer that is in range and legal goes to SETUP. A valid transfer that is out of range or illegal goes to ERR1.
  - SETUP: Pselx[idx]=1, Penable=0, Hreadyout=0. Always goes to ACCESS.
  - ACCESS: Penable=1, Hreadyout=0.
    - Pready && !Pslverr: Hrdata<=Prdata on reads, then go to IDLE. The IDLE cycle is the completion cycle, with Hreadyout=1 and Hresp=OKAY.
    - Pready && Pslverr: go to ERR1.
    - Timeout counter reaches TIMEOUT with Pready low: drop Pselx and Penable, go to ERR1.
  - ERR1: Hresp=01, Hreadyout=0. Goes to ERR2.
  - ERR2: Hresp=01, Hreadyout=1. A valid transfer sampled here is accepted exactly as in IDLE; otherwise go to IDLE.
- Pwdata passes Hwdata through. The AHB master holds Hwdata for the whole data phase because Hreadyout is low.
- Timeout counter: cleared on SETUP entry; increments each ACCESS cycle with Pready low; saturates at TIMEOUT.
- Pwrite and Paddr hold from SETUP through ACCESS. Pselx and Penable are 0 in every other state.

## Timing
- Reset values: Hreadyout=1, Hresp=00, Hrdata=0, Pselx=0, Penable=0, Pwrite=0, Paddr=0, state=IDLE, counter=0.
- Reset asserted mid-transfer forces all outputs to their reset values immediately; there is no APB completion.
- Address phase at cycle N: SETUP at N+1, ACCESS at N+2.
- With zero-wait APB, completion (Hreadyout=1, Hrdata valid) is at N+3. Each Pready-low cycle adds one cycle.
- Back-to-back: the next address phase is sampled in the completion cycle, so its SETUP is at N+4.
- ERROR: two cycles, ERR1 then ERR2. For decode or size errors, ERR1 starts at N+1.

## Configuration
- AHB_APB_PSTRB_EN defined:
  - Adds output Pstrb[WIDTH/8]: contiguous byte lanes from Hsize and Haddr[log2(WIDTH/8)-1:0] on writes; all zero on reads.
  - Unaligned transfers (Haddr not a multiple of the size) produce ERROR.
- Undefined: no Pstrb port, and the alignment check is omitted.

## Structure
- Package ahb_apb_pkg holds:
  - htrans_e and hresp_e enums.
  - the state_e typedef.
  - constants HRESP_OKAY and HRESP_ERROR.
- Sub-module apb_addr_decode: combinational range check, index and one-hot select, parametrised by WIDTH, NUM_SLV, BASE_ADDR and SLV_AW.

## Test plan
- Zero-wait read: NONSEQ read at 0x8000_1004, Prdata=0xDEAD_BEEF, Pready=1 → Pselx=4'b0010 at N+1, Penable at N+2, Hrdata=0xDEAD_BEEF with Hreadyout=1 at N+3.
- Wait-state write: write 0x1234_5678 to 0x8000_3000, Pready low for 3 cycles → Pselx=4'b1000, Pwdata stable, Hreadyout=1 at N+6, Hresp=OKAY.
- Out-of-range: NONSEQ to 0x8000_4000 → no Pselx, Hresp=01 with Hreadyout=0 at N+1, then Hreadyout=1 at N+2.
- Pslverr and timeout:
  - Pready=1 with Pslverr=1 → two-cycle ERROR.
  - With TIMEOUT=16 and Pready held low, ERR1 follows the 16th ACCESS cycle and Pselx drops.
- Back-to-back plus reset: two NONSEQ reads pipelined → second SETUP at N+4. Hresetn pulsed low during ACCESS → all outputs return to reset values the same cycle.
